// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 instruction codes, encoder state and length helper
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Register id meaning "no register" in an rA/rB slot
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;

  // Encoded length in bytes; undefined icodes report 1 so callers
  // always see a non-zero length (validity is judged separately).
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      IHALT, INOP, IRET:                 len = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:      len = 4'd2;
      IJXX, ICALL:                       len = 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:         len = 4'd10;
      default:                           len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// rtl/y86_instr_len.sv - combinational icode decode into length and byte layout
module y86_instr_len (
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       valid,
  output logic       has_regs,
  output logic [3:0] valc_offset
);
  import y86_pkg::*;

  // Layout: byte 1 holds {rA,rB} when has_regs; valC starts at valc_offset (0 = no valC)
  always_comb begin
    len         = instr_len(icode);
    valid       = (icode <= IPOPQ);
    has_regs    = 1'b0;
    valc_offset = 4'd0;
    case (icode)
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        has_regs = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        has_regs    = 1'b1;
        valc_offset = 4'd2;
      end
      IJXX, ICALL: begin
        valc_offset = 4'd1;
      end
      default: begin
        has_regs    = 1'b0;
        valc_offset = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// rtl/y86_instr_encoder.sv - serializes Y86-64 instruction fields into byte-wide memory writes
module y86_instr_encoder #(
  parameter logic [63:0] MEM_SIZE  = 64'd1024,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_addr,
  input  logic [63:0] new_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        done,
  output logic [63:0] next_addr,
  output logic        instr_invalid,
  output logic        mem_error
);
  import y86_pkg::*;

  enc_state_e  state, state_nx;
  logic [63:0] addr;
  logic [3:0]  cnt;

  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [63:0] valc_q;
  logic [3:0]  len_q;
  logic        has_regs_q;
  logic [3:0]  valc_off_q;

  logic [3:0]  dec_len;
  logic        dec_valid;
  logic        dec_has_regs;
  logic [3:0]  dec_valc_off;

  logic        last_byte;
  logic [63:0] base_addr_nx;
  logic [64:0] span;
  logic        fits;
  logic        accept;
  logic        take;
  logic        reject_invalid;
  logic        reject_mem;
  logic [2:0]  valc_sel;

  y86_instr_len u_len (
    .icode       (icode),
    .len         (dec_len),
    .valid       (dec_valid),
    .has_regs    (dec_has_regs),
    .valc_offset (dec_valc_off)
  );

  // Acceptance decision; a new instruction on the last byte is checked against the post-increment address
  always_comb begin
    last_byte      = (state == ST_EMIT) && (cnt == (len_q - 4'd1));
    base_addr_nx   = last_byte ? (addr + {60'd0, len_q}) : addr;
    span           = {1'b0, base_addr_nx} + {61'd0, dec_len};
    fits           = (span <= {1'b0, MEM_SIZE});
    accept         = in_valid && in_ready;
    take           = accept && dec_valid && fits;
    reject_invalid = accept && !dec_valid;
    reject_mem     = accept && dec_valid && !fits;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state: stay in EMIT across back-to-back instructions, fall to IDLE otherwise
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = take ? ST_EMIT : ST_IDLE;
      ST_EMIT: begin
        if (last_byte) state_nx = take ? ST_EMIT : ST_IDLE;
        else           state_nx = ST_EMIT;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs: handshake, byte mux and write strobe (all zero outside EMIT)
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 64'd0;
    wr_data  = 8'd0;
    done     = 1'b0;
    valc_sel = 3'(cnt - valc_off_q);
    case (state)
      ST_IDLE: in_ready = !set_addr;
      ST_EMIT: begin
        in_ready = last_byte;
        wr_en    = 1'b1;
        done     = last_byte;
        wr_addr  = addr + {60'd0, cnt};
        if (cnt == 4'd0)
          wr_data = {icode_q, ifun_q};
        else if (has_regs_q && (cnt == 4'd1))
          wr_data = {ra_q, rb_q};
        else
          wr_data = valc_q[{valc_sel, 3'b000} +: 8];
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: address register, field latches, byte counter and rejection pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= BASE_ADDR;
      cnt           <= 4'd0;
      icode_q       <= 4'd0;
      ifun_q        <= 4'd0;
      ra_q          <= RNONE;
      rb_q          <= RNONE;
      valc_q        <= 64'd0;
      len_q         <= 4'd1;
      has_regs_q    <= 1'b0;
      valc_off_q    <= 4'd0;
      instr_invalid <= 1'b0;
      mem_error     <= 1'b0;
    end else begin
      instr_invalid <= reject_invalid;
      mem_error     <= reject_mem;

      if ((state == ST_IDLE) && set_addr)
        addr <= new_addr;
      else if (last_byte)
        addr <= base_addr_nx;

      if (take) begin
        icode_q    <= icode;
        ifun_q     <= ifun;
        ra_q       <= rA;
        rb_q       <= rB;
        valc_q     <= valC;
        len_q      <= dec_len;
        has_regs_q <= dec_has_regs;
        valc_off_q <= dec_valc_off;
        cnt        <= 4'd0;
      end else if ((state == ST_EMIT) && !last_byte) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
    end
  end

  assign next_addr = addr;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// tb/tb_y86_instr_encoder.sv - directed self-checking bench for y86_instr_encoder
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_addr = 1'b0;
  logic [63:0] new_addr = 64'd0;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = 4'd0, ifun = 4'd0, rA = 4'hF, rB = 4'hF;
  logic [63:0] valC = 64'd0;

  logic        in_ready, wr_en, done, instr_invalid, mem_error;
  logic [63:0] wr_addr, next_addr;
  logic [7:0]  wr_data;

  logic        s_in_ready, s_wr_en, s_done, s_instr_invalid, s_mem_error;
  logic [63:0] s_wr_addr, s_next_addr;
  logic [7:0]  s_wr_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  y86_instr_encoder u_dut (
    .clk(clk), .rst(rst), .set_addr(set_addr), .new_addr(new_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done),
    .next_addr(next_addr), .instr_invalid(instr_invalid), .mem_error(mem_error)
  );

  y86_instr_encoder #(.MEM_SIZE(64'd16), .BASE_ADDR(64'd0)) u_small (
    .clk(clk), .rst(rst), .set_addr(set_addr), .new_addr(new_addr),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .done(s_done),
    .next_addr(s_next_addr), .instr_invalid(s_instr_invalid), .mem_error(s_mem_error)
  );

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    in_valid = v; icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; set_addr = 1'b0; new_addr = 64'd0;
    drive(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_vec++;
    if ({wr_en, done, instr_invalid, mem_error} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes got=%b exp=0000", {wr_en, done, instr_invalid, mem_error});
    end
    n_vec++;
    if ({wr_addr, wr_data} !== 72'd0) begin
      n_err++; $display("FAIL reset_wr_bus got=%h/%h exp=0/0", wr_addr, wr_data);
    end
    n_vec++;
    if (next_addr !== 64'd0) begin n_err++; $display("FAIL reset_next_addr got=%h exp=0", next_addr); end
    rst = 1'b0;
  endtask

  task automatic test_irmovq;
    logic [7:0] exp_b [10];
    exp_b = '{8'h30, 8'hF2, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    do_reset();
    drive(1'b1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL irmovq_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_vec++;
      if ({wr_en, wr_addr, wr_data, done} !== {1'b1, 64'(k), exp_b[k], (k == 9)}) begin
        n_err++;
        $display("FAIL irmovq_byte%0d got en=%b a=%h d=%h done=%b exp en=1 a=%h d=%h done=%b",
                 k, wr_en, wr_addr, wr_data, done, 64'(k), exp_b[k], (k == 9));
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if ({wr_en, next_addr} !== {1'b0, 64'd10}) begin
      n_err++; $display("FAIL irmovq_end got en=%b next=%h exp en=0 next=a", wr_en, next_addr);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] call_b [9];
    call_b = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    drive(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    @(negedge clk);
    drive(1'b1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, done, in_ready} !== {1'b1, 64'd0, 8'h10, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL b2b_nop got en=%b a=%h d=%h done=%b rdy=%b exp 1/0/10/1/1",
                        wr_en, wr_addr, wr_data, done, in_ready);
    end
    @(negedge clk);
    drive(1'b1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h40);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, done, in_ready} !== {1'b1, 64'd1, 8'h00, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL b2b_halt got en=%b a=%h d=%h done=%b rdy=%b exp 1/1/00/1/1",
                        wr_en, wr_addr, wr_data, done, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      n_vec++;
      if ({wr_en, wr_addr, wr_data, done} !== {1'b1, 64'(k + 2), call_b[k], (k == 8)}) begin
        n_err++;
        $display("FAIL b2b_call_byte%0d got en=%b a=%h d=%h done=%b exp en=1 a=%h d=%h done=%b",
                 k, wr_en, wr_addr, wr_data, done, 64'(k + 2), call_b[k], (k == 8));
      end
      if (k == 3) begin
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_mid_ready got=%b exp=0", in_ready); end
      end
      @(negedge clk);
    end
    #1;
    n_vec++;
    if ({wr_en, next_addr} !== {1'b0, 64'd11}) begin
      n_err++; $display("FAIL b2b_end got en=%b next=%h exp en=0 next=b", wr_en, next_addr);
    end
  endtask

  task automatic test_set_addr;
    do_reset();
    set_addr = 1'b1; new_addr = 64'h20;
    drive(1'b1, 4'h2, 4'h0, 4'h1, 4'h3, 64'd0);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL setaddr_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    set_addr = 1'b0;
    #1;
    n_vec++;
    if ({wr_en, next_addr, in_ready} !== {1'b0, 64'h20, 1'b1}) begin
      n_err++; $display("FAIL setaddr_load got en=%b next=%h rdy=%b exp 0/20/1", wr_en, next_addr, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    set_addr = 1'b1; new_addr = 64'h100;
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, done} !== {1'b1, 64'h20, 8'h20, 1'b0}) begin
      n_err++; $display("FAIL setaddr_byte0 got en=%b a=%h d=%h done=%b exp 1/20/20/0", wr_en, wr_addr, wr_data, done);
    end
    @(negedge clk);
    set_addr = 1'b0;
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, done} !== {1'b1, 64'h21, 8'h13, 1'b1}) begin
      n_err++; $display("FAIL setaddr_byte1 got en=%b a=%h d=%h done=%b exp 1/21/13/1", wr_en, wr_addr, wr_data, done);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({wr_en, next_addr} !== {1'b0, 64'h22}) begin
      n_err++; $display("FAIL setaddr_end got en=%b next=%h exp 0/22", wr_en, next_addr);
    end
  endtask

  task automatic test_invalid;
    do_reset();
    drive(1'b1, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({instr_invalid, mem_error, wr_en, in_ready, next_addr} !== {4'b1001, 64'd0}) begin
      n_err++; $display("FAIL invalid_pulse got inv=%b me=%b en=%b rdy=%b next=%h exp 1/0/0/1/0",
                        instr_invalid, mem_error, wr_en, in_ready, next_addr);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({instr_invalid, wr_en} !== 2'b00) begin
      n_err++; $display("FAIL invalid_one_cycle got inv=%b en=%b exp 0/0", instr_invalid, wr_en);
    end
    @(negedge clk);
    set_addr = 1'b1; new_addr = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    set_addr = 1'b0;
    drive(1'b1, 4'hD, 4'h0, 4'hF, 4'hF, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({instr_invalid, mem_error, s_instr_invalid, s_mem_error} !== 4'b1010) begin
      n_err++; $display("FAIL both_bad got inv=%b me=%b s_inv=%b s_me=%b exp 1/0/1/0",
                        instr_invalid, mem_error, s_instr_invalid, s_mem_error);
    end
    @(negedge clk);
    drive(1'b1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({instr_invalid, mem_error, wr_en, next_addr} !== {3'b010, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_err++; $display("FAIL wrap_mem_error got inv=%b me=%b en=%b next=%h exp 0/1/0/ffffffffffffffff",
                        instr_invalid, mem_error, wr_en, next_addr);
    end
  endtask

  task automatic test_mem_error;
    do_reset();
    set_addr = 1'b1; new_addr = 64'd8;
    @(negedge clk);
    set_addr = 1'b0;
    drive(1'b1, 4'h5, 4'h0, 4'h3, 4'h4, 64'h1122334455667788);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({s_mem_error, s_instr_invalid, s_wr_en, s_next_addr} !== {3'b100, 64'd8}) begin
      n_err++; $display("FAIL mem_error_pulse got me=%b inv=%b en=%b next=%h exp 1/0/0/8",
                        s_mem_error, s_instr_invalid, s_wr_en, s_next_addr);
    end
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 64'd8, 8'h50}) begin
      n_err++; $display("FAIL mem_big_accept got en=%b a=%h d=%h exp 1/8/50", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({s_mem_error, s_wr_en} !== 2'b00) begin
      n_err++; $display("FAIL mem_error_one_cycle got me=%b en=%b exp 0/0", s_mem_error, s_wr_en);
    end
    repeat (9) @(negedge clk);
    set_addr = 1'b1; new_addr = 64'd6;
    @(negedge clk);
    set_addr = 1'b0;
    drive(1'b1, 4'h5, 4'h0, 4'h3, 4'h4, 64'h1122334455667788);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({s_mem_error, s_wr_en, s_wr_addr, s_wr_data} !== {2'b01, 64'd6, 8'h50}) begin
      n_err++; $display("FAIL exact_fit_first got me=%b en=%b a=%h d=%h exp 0/1/6/50",
                        s_mem_error, s_wr_en, s_wr_addr, s_wr_data);
    end
    repeat (9) @(negedge clk);
    #1;
    n_vec++;
    if ({s_wr_en, s_done, s_wr_addr, s_wr_data} !== {2'b11, 64'd15, 8'h11}) begin
      n_err++; $display("FAIL exact_fit_last got en=%b done=%b a=%h d=%h exp 1/1/f/11",
                        s_wr_en, s_done, s_wr_addr, s_wr_data);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({s_wr_en, s_next_addr} !== {1'b0, 64'd16}) begin
      n_err++; $display("FAIL exact_fit_end got en=%b next=%h exp 0/10", s_wr_en, s_next_addr);
    end
  endtask

  task automatic test_reset_mid_emit;
    do_reset();
    drive(1'b1, 4'h4, 4'h0, 4'h1, 4'h2, 64'hAABBCCDDEEFF0011);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 64'd2, 8'h11}) begin
      n_err++; $display("FAIL rmmovq_byte2 got en=%b a=%h d=%h exp 1/2/11", wr_en, wr_addr, wr_data);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if ({wr_en, done, in_ready, next_addr} !== {3'b001, 64'd0}) begin
      n_err++; $display("FAIL abort got en=%b done=%b rdy=%b next=%h exp 0/0/1/0",
                        wr_en, done, in_ready, next_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if ({wr_en, next_addr} !== {1'b0, 64'd0}) begin
      n_err++; $display("FAIL abort_idle got en=%b next=%h exp 0/0", wr_en, next_addr);
    end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_back_to_back();
    test_set_addr();
    test_invalid();
    test_mem_error();
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
